// File: rtl/acq_sequencer.sv
// ---------------------------------------------------------------------------
// acq_sequencer
// Acquisition command sequencer that sits behind the SPI register block, in
// the iclk domain. The host writes an instruction byte (sclk domain). A new
// command is issued by flipping instruction[7]. The byte is brought into iclk
// through a two-stage synchronizer. A command is accepted only when both
// stages agree, so a byte caught mid-change is never decoded.
//
// Sequence: IDLE -> ARMED -> TRIG (pulse) -> READ (handshake) -> IDLE/ARMED,
// with CLR reachable from every state except CLR itself.
//
// Ports
//   iclk, rstn               clock and asynchronous active-low reset
//   instruction[7:0]         [7] command toggle, [3:0] opcode (sclk domain)
//   mode[7:0]                [0] auto-rearm after readout
//   trigger_channel_mask[7:0] channel mask, captured on TRIG entry
//   ext_trig                 external trigger level (rising edge used)
//   readout_ack              readout consumer done
//   acq_en, trig_out[7:0], readout_req, clear_out, busy  state outputs
//   cmd_err, timeout_err     sticky error flags
//   trig_count[7:0]          triggers taken, wraps 255 -> 0
//
// Configuration macro: ACQ_READOUT_TIMEOUT_EN
//   When defined, READ gives up after READOUT_TIMEOUT cycles without
//   readout_ack. It then sets timeout_err and returns to IDLE.
//   When undefined, READ waits for readout_ack indefinitely, and
//   timeout_err is tied to 0.
// ---------------------------------------------------------------------------
module acq_sequencer #(
    parameter int TRIG_CYCLES     = 4,
    parameter int CLR_CYCLES      = 8,
    parameter int READOUT_TIMEOUT = 1024
) (
    input  logic       iclk,
    input  logic       rstn,
    input  logic [7:0] instruction,
    input  logic [7:0] mode,
    input  logic [7:0] trigger_channel_mask,
    input  logic       ext_trig,
    input  logic       readout_ack,
    output logic       acq_en,
    output logic [7:0] trig_out,
    output logic       readout_req,
    output logic       clear_out,
    output logic       busy,
    output logic       cmd_err,
    output logic       timeout_err,
    output logic [7:0] trig_count
);

    localparam int PULSE_MAX = (TRIG_CYCLES > CLR_CYCLES) ? TRIG_CYCLES : CLR_CYCLES;
    localparam int CNT_W     = $clog2(PULSE_MAX) + 1;
    localparam logic [CNT_W-1:0] TRIG_LOAD = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_START     = 4'd1;
    localparam logic [3:0] OP_STOP      = 4'd2;
    localparam logic [3:0] OP_SOFT_TRIG = 4'd3;
    localparam logic [3:0] OP_READOUT   = 4'd4;
    localparam logic [3:0] OP_CLEAR     = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_TRIG,
        S_READ,
        S_CLR
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       sync1_q, sync2_q;
    logic             last_tog_q, last_tog_d;
    logic             ext_trig_dly_q;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [7:0]       trig_out_q, trig_out_d;
    logic [7:0]       trig_count_q, trig_count_d;
    logic             cmd_err_q, cmd_err_d;
    logic             acq_en_q, readout_req_q, clear_out_q, busy_q;

`ifdef ACQ_READOUT_TIMEOUT_EN
    localparam int TMO_W = $clog2(READOUT_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(READOUT_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    logic       cmd_valid;
    logic [3:0] opcode;
    logic       op_legal;
    logic       ext_rise;
    logic       is_clear;
    logic       go_trig, go_read, go_clr, set_err;

    // Both synchronizer stages must agree, so an instruction byte that is
    // changing while it is sampled is ignored until it is stable.
    assign cmd_valid = (sync2_q == sync1_q) && (sync2_q[7] != last_tog_q);
    assign opcode    = sync2_q[3:0];
    assign op_legal  = (opcode <= OP_CLEAR);
    assign ext_rise  = ext_trig & ~ext_trig_dly_q;
    assign is_clear  = cmd_valid && (opcode == OP_CLEAR);

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        last_tog_d   = last_tog_q;
        pulse_cnt_d  = pulse_cnt_q;
        trig_out_d   = trig_out_q;
        trig_count_d = trig_count_q;
        cmd_err_d    = cmd_err_q;
        go_trig      = 1'b0;
        go_read      = 1'b0;
        go_clr       = 1'b0;
        set_err      = 1'b0;
`ifdef ACQ_READOUT_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        // Consume every accepted toggle, even when the command is rejected.
        if (cmd_valid) last_tog_d = sync2_q[7];

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (opcode)
                        OP_START:        state_d = S_ARMED;
                        OP_SOFT_TRIG:    go_trig = 1'b1;
                        OP_READOUT:      go_read = 1'b1;
                        OP_CLEAR:        go_clr  = 1'b1;
                        OP_NOP, OP_STOP: ;
                        default:         set_err = 1'b1;
                    endcase
                end
            end
            S_ARMED: begin
                // Same-cycle priority: CLEAR, then STOP, then any trigger.
                if (is_clear) begin
                    go_clr = 1'b1;
                end else if (cmd_valid && (opcode == OP_STOP)) begin
                    state_d = S_IDLE;
                end else begin
                    if (ext_rise || (cmd_valid && (opcode == OP_SOFT_TRIG))) go_trig = 1'b1;
                    if (cmd_valid && ((opcode == OP_READOUT) || !op_legal)) set_err = 1'b1;
                end
            end
            S_TRIG: begin
                if (is_clear) begin
                    go_clr = 1'b1;
                end else begin
                    if (cmd_valid) set_err = 1'b1;
                    if (pulse_cnt_q == '0) go_read = 1'b1;
                    else                   pulse_cnt_d = pulse_cnt_q - CNT_ONE;
                end
            end
            S_READ: begin
                if (is_clear) begin
                    go_clr = 1'b1;
                end else begin
                    if (cmd_valid) set_err = 1'b1;
                    if (readout_ack) begin
                        state_d = mode[0] ? S_ARMED : S_IDLE;
                    end
`ifdef ACQ_READOUT_TIMEOUT_EN
                    else if (tmo_cnt_q == '0) begin
                        state_d       = S_IDLE;
                        timeout_err_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                    end
`endif
                end
            end
            S_CLR: begin
                if (cmd_valid) set_err = 1'b1;
                if (pulse_cnt_q == '0) state_d = S_IDLE;
                else                   pulse_cnt_d = pulse_cnt_q - CNT_ONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (set_err) cmd_err_d = 1'b1;

        // An empty mask is a rejected trigger: the state is left unchanged.
        if (go_trig) begin
            if (trigger_channel_mask == 8'h00) begin
                cmd_err_d = 1'b1;
            end else begin
                state_d      = S_TRIG;
                trig_out_d   = trigger_channel_mask;
                pulse_cnt_d  = TRIG_LOAD;
                trig_count_d = trig_count_q + 8'd1;
            end
        end

        if (go_read) begin
            state_d = S_READ;
`ifdef ACQ_READOUT_TIMEOUT_EN
            tmo_cnt_d = TMO_LOAD;
`endif
        end

        if (go_clr) begin
            state_d      = S_CLR;
            pulse_cnt_d  = CLR_LOAD;
            trig_count_d = 8'h00;
            cmd_err_d    = 1'b0;
`ifdef ACQ_READOUT_TIMEOUT_EN
            timeout_err_d = 1'b0;
`endif
        end

        if (state_d != S_TRIG) trig_out_d = 8'h00;
    end

    // Outputs are decoded from the next state and registered, so each one
    // changes on the same edge as the state.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            sync1_q        <= 8'h00;
            sync2_q        <= 8'h00;
            last_tog_q     <= 1'b0;
            ext_trig_dly_q <= 1'b0;
            pulse_cnt_q    <= '0;
            trig_out_q     <= 8'h00;
            trig_count_q   <= 8'h00;
            cmd_err_q      <= 1'b0;
            acq_en_q       <= 1'b0;
            readout_req_q  <= 1'b0;
            clear_out_q    <= 1'b0;
            busy_q         <= 1'b0;
`ifdef ACQ_READOUT_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here, so every register samples pre-edge values.
            state_q        <= state_d;
            sync1_q        <= instruction;
            sync2_q        <= sync1_q;
            last_tog_q     <= last_tog_d;
            ext_trig_dly_q <= ext_trig;
            pulse_cnt_q    <= pulse_cnt_d;
            trig_out_q     <= trig_out_d;
            trig_count_q   <= trig_count_d;
            cmd_err_q      <= cmd_err_d;
            acq_en_q       <= (state_d == S_ARMED);
            readout_req_q  <= (state_d == S_READ);
            clear_out_q    <= (state_d == S_CLR);
            busy_q         <= (state_d == S_TRIG) || (state_d == S_READ) || (state_d == S_CLR);
`ifdef ACQ_READOUT_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
            timeout_err_q  <= timeout_err_d;
`endif
        end
    end

    assign acq_en      = acq_en_q;
    assign trig_out    = trig_out_q;
    assign readout_req = readout_req_q;
    assign clear_out   = clear_out_q;
    assign busy        = busy_q;
    assign cmd_err     = cmd_err_q;
    assign trig_count  = trig_count_q;

    // Byte fields that carry no function in this block.
    logic unused_bits;
`ifdef ACQ_READOUT_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
    assign unused_bits = ^{mode[7:1]};
`else
    assign timeout_err = 1'b0;
    assign unused_bits = ^{mode[7:1], 32'(READOUT_TIMEOUT)};
`endif

endmodule

// File: tb/tb_acq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_acq_sequencer
// Table-driven command vectors, followed by hand-written multi-cycle sequences:
//   - external trigger with auto-rearm
//   - reset in the middle of TRIG
//   - toggle reuse (the same toggle value written twice)
//   - empty-mask trigger
//   - CLEAR while in TRIG
//   - readout timeout
// Expected trigger pulses are queued when a trigger is issued. A monitor
// compares them when trig_out rises.
// ---------------------------------------------------------------------------
module tb_acq_sequencer;

    localparam logic [3:0] OP_NOP = 4'd0, OP_START = 4'd1, OP_STOP = 4'd2;
    localparam logic [3:0] OP_SOFT = 4'd3, OP_READOUT = 4'd4, OP_CLEAR = 4'd5;

    logic       iclk = 1'b0;
    logic       rstn;
    logic [7:0] instruction, mode, trigger_channel_mask;
    logic       ext_trig, readout_ack;
    logic       acq_en, readout_req, clear_out, busy, cmd_err, timeout_err;
    logic [7:0] trig_out, trig_count;

    acq_sequencer #(
        .TRIG_CYCLES    (4),
        .CLR_CYCLES     (8),
        .READOUT_TIMEOUT(16)
    ) dut (
        .iclk                (iclk),
        .rstn                (rstn),
        .instruction         (instruction),
        .mode                (mode),
        .trigger_channel_mask(trigger_channel_mask),
        .ext_trig            (ext_trig),
        .readout_ack         (readout_ack),
        .acq_en              (acq_en),
        .trig_out            (trig_out),
        .readout_req         (readout_req),
        .clear_out           (clear_out),
        .busy                (busy),
        .cmd_err             (cmd_err),
        .timeout_err         (timeout_err),
        .trig_count          (trig_count)
    );

    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_pass   = 0;
    bit tog      = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge iclk);
    endtask

    task automatic send(input logic [3:0] op, input bit flip);
        if (flip) tog = ~tog;
        instruction = {tog, 3'b000, op};
    endtask

    task automatic check_outs(input string tag, input bit e_acq, input bit e_busy, input bit e_req,
                              input bit e_clr, input bit e_err, input logic [7:0] e_cnt,
                              input logic [7:0] e_trig);
        check({tag, "_acq_en"},      8'(acq_en),      8'(e_acq));
        check({tag, "_busy"},        8'(busy),        8'(e_busy));
        check({tag, "_readout_req"}, 8'(readout_req), 8'(e_req));
        check({tag, "_clear_out"},   8'(clear_out),   8'(e_clr));
        check({tag, "_cmd_err"},     8'(cmd_err),     8'(e_err));
        check({tag, "_trig_count"},  trig_count,      e_cnt);
        check({tag, "_trig_out"},    trig_out,        e_trig);
    endtask

    task automatic ack_pulse();
        readout_ack = 1'b1;
        step(1);
        readout_ack = 1'b0;
    endtask

    // Scoreboard of expected trigger pulses.
    typedef struct packed {
        logic [7:0] mask;
        logic [7:0] cnt;
    } sb_t;
    sb_t        exp_q[$];
    sb_t        sb_e;
    logic [7:0] prev_trig = 8'h00;

    always @(negedge iclk) begin
        if (trig_out != 8'h00 && prev_trig == 8'h00) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pulse", trig_out, 8'h00);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_mask", trig_out, sb_e.mask);
                check("sb_count", trig_count, sb_e.cnt);
            end
        end
        prev_trig = trig_out;
    end

    typedef struct {
        bit         issue;
        logic [3:0] op;
        bit         ack;
        bit         mode0;
        logic [7:0] mask;
        int         wait_n;
        bit         sb;
        bit         e_acq, e_busy, e_req, e_clr, e_err;
        logic [7:0] e_cnt, e_trig;
    } vec_t;

    function automatic vec_t mk(bit issue, logic [3:0] op, bit ack, bit mode0, logic [7:0] mask,
                                int wait_n, bit sb, bit e_acq, bit e_busy, bit e_req, bit e_clr,
                                bit e_err, logic [7:0] e_cnt, logic [7:0] e_trig);
        vec_t v;
        v.issue = issue; v.op = op; v.ack = ack; v.mode0 = mode0; v.mask = mask;
        v.wait_n = wait_n; v.sb = sb; v.e_acq = e_acq; v.e_busy = e_busy; v.e_req = e_req;
        v.e_clr = e_clr; v.e_err = e_err; v.e_cnt = e_cnt; v.e_trig = e_trig;
        return v;
    endfunction

    localparam int NV = 22;
    vec_t tbl[NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //               iss op          ack m0 mask   w  sb  acq bsy req clr err cnt    trig
        tbl[0]  = mk(1, OP_NOP,     0, 0, 8'h5A, 4,  0, 0, 0, 0, 0, 0, 8'd0, 8'h00);
        tbl[1]  = mk(1, OP_START,   0, 0, 8'h5A, 4,  0, 1, 0, 0, 0, 0, 8'd0, 8'h00);
        tbl[2]  = mk(1, OP_START,   0, 0, 8'h5A, 4,  0, 1, 0, 0, 0, 0, 8'd0, 8'h00);
        tbl[3]  = mk(1, OP_READOUT, 0, 0, 8'h5A, 4,  0, 1, 0, 0, 0, 1, 8'd0, 8'h00);
        tbl[4]  = mk(1, OP_STOP,    0, 0, 8'h5A, 4,  0, 0, 0, 0, 0, 1, 8'd0, 8'h00);
        tbl[5]  = mk(1, OP_CLEAR,   0, 0, 8'h5A, 3,  0, 0, 1, 0, 1, 0, 8'd0, 8'h00);
        tbl[6]  = mk(0, OP_NOP,     0, 0, 8'h5A, 7,  0, 0, 1, 0, 1, 0, 8'd0, 8'h00);
        tbl[7]  = mk(0, OP_NOP,     0, 0, 8'h5A, 1,  0, 0, 0, 0, 0, 0, 8'd0, 8'h00);
        tbl[8]  = mk(1, 4'd9,       0, 0, 8'h5A, 4,  0, 0, 0, 0, 0, 1, 8'd0, 8'h00);
        tbl[9]  = mk(1, OP_SOFT,    0, 0, 8'h5A, 3,  1, 0, 1, 0, 0, 1, 8'd1, 8'h5A);
        tbl[10] = mk(0, OP_NOP,     0, 0, 8'h5A, 3,  0, 0, 1, 0, 0, 1, 8'd1, 8'h5A);
        tbl[11] = mk(0, OP_NOP,     0, 0, 8'h5A, 1,  0, 0, 1, 1, 0, 1, 8'd1, 8'h00);
        tbl[12] = mk(0, OP_NOP,     0, 0, 8'h5A, 10, 0, 0, 1, 1, 0, 1, 8'd1, 8'h00);
        tbl[13] = mk(0, OP_NOP,     1, 0, 8'h5A, 1,  0, 0, 0, 0, 0, 1, 8'd1, 8'h00);
        tbl[14] = mk(1, OP_CLEAR,   0, 0, 8'h5A, 11, 0, 0, 0, 0, 0, 0, 8'd0, 8'h00);
        tbl[15] = mk(1, OP_START,   0, 1, 8'h5A, 4,  0, 1, 0, 0, 0, 0, 8'd0, 8'h00);
        tbl[16] = mk(1, OP_SOFT,    0, 1, 8'h3C, 3,  1, 0, 1, 0, 0, 0, 8'd1, 8'h3C);
        tbl[17] = mk(0, OP_NOP,     0, 1, 8'h3C, 4,  0, 0, 1, 1, 0, 0, 8'd1, 8'h00);
        tbl[18] = mk(1, OP_STOP,    0, 1, 8'h3C, 4,  0, 0, 1, 1, 0, 1, 8'd1, 8'h00);
        tbl[19] = mk(0, OP_NOP,     1, 1, 8'h3C, 1,  0, 1, 0, 0, 0, 1, 8'd1, 8'h00);
        tbl[20] = mk(1, OP_STOP,    0, 0, 8'h3C, 4,  0, 0, 0, 0, 0, 1, 8'd1, 8'h00);
        tbl[21] = mk(0, OP_NOP,     1, 0, 8'h3C, 2,  0, 0, 0, 0, 0, 1, 8'd1, 8'h00);

        rstn = 1'b0;
        instruction = 8'h00;
        mode = 8'h00;
        trigger_channel_mask = 8'h5A;
        ext_trig = 1'b0;
        readout_ack = 1'b0;
        #1;
        check_outs("reset", 0, 0, 0, 0, 0, 8'd0, 8'h00);
        check("reset_timeout_err", 8'(timeout_err), 8'h00);
        step(2);
        rstn = 1'b1;
        step(2);

        // Table-driven command vectors.
        for (int i = 0; i < NV; i++) begin
            mode = {7'd0, tbl[i].mode0};
            trigger_channel_mask = tbl[i].mask;
            if (tbl[i].sb) exp_q.push_back(sb_t'({tbl[i].mask, tbl[i].e_cnt}));
            if (tbl[i].issue) send(tbl[i].op, 1'b1);
            if (tbl[i].ack) begin
                ack_pulse();
                step(tbl[i].wait_n - 1);
            end else begin
                step(tbl[i].wait_n);
            end
            check_outs($sformatf("v%0d", i), tbl[i].e_acq, tbl[i].e_busy, tbl[i].e_req,
                       tbl[i].e_clr, tbl[i].e_err, tbl[i].e_cnt, tbl[i].e_trig);
        end

        // External trigger with auto-rearm, then without it.
        mode = 8'h01;
        trigger_channel_mask = 8'hA5;
        send(OP_START, 1'b1);
        step(4);
        check("ext_armed_acq_en", 8'(acq_en), 8'h01);
        exp_q.push_back(sb_t'({8'hA5, 8'd2}));
        ext_trig = 1'b1;
        step(1);
        check("ext_trig_out", trig_out, 8'hA5);
        step(4);
        check("ext_read_req", 8'(readout_req), 8'h01);
        check("ext_read_trig_off", trig_out, 8'h00);
        step(9);
        check("ext_req_held", 8'(readout_req), 8'h01);
        ack_pulse();
        check("rearm_req_drop", 8'(readout_req), 8'h00);
        check("rearm_acq_en", 8'(acq_en), 8'h01);
        ext_trig = 1'b0;
        mode = 8'h00;
        step(1);
        exp_q.push_back(sb_t'({8'hA5, 8'd3}));
        ext_trig = 1'b1;
        step(5);
        check("ext2_req", 8'(readout_req), 8'h01);
        ack_pulse();
        check("norearm_acq_en", 8'(acq_en), 8'h00);
        check("norearm_busy", 8'(busy), 8'h00);
        ext_trig = 1'b0;

        // Reset in the middle of TRIG.
        trigger_channel_mask = 8'hFF;
        send(OP_SOFT, 1'b1);
        exp_q.push_back(sb_t'({8'hFF, 8'd4}));
        step(4);
        check("pre_reset_trig", trig_out, 8'hFF);
        #2 rstn = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 0, 8'd0, 8'h00);
        instruction = 8'h00;
        tog = 1'b0;
        step(2);
        rstn = 1'b1;
        step(5);
        check_outs("post_rst", 0, 0, 0, 0, 0, 8'd0, 8'h00);

        // Writing the same toggle value twice must not issue a second command.
        trigger_channel_mask = 8'h11;
        instruction = 8'h83;
        tog = 1'b1;
        exp_q.push_back(sb_t'({8'h11, 8'd1}));
        step(3);
        check("tog1_trig", trig_out, 8'h11);
        step(4);
        check("tog1_req", 8'(readout_req), 8'h01);
        ack_pulse();
        check("tog1_idle", 8'(busy), 8'h00);
        instruction = 8'h83;
        step(10);
        check("tog_same_count", trig_count, 8'd1);
        check("tog_same_busy", 8'(busy), 8'h00);
        instruction = 8'h03;
        tog = 1'b0;
        exp_q.push_back(sb_t'({8'h11, 8'd2}));
        step(3);
        check("tog2_trig", trig_out, 8'h11);
        step(4);
        ack_pulse();
        check("tog2_idle", 8'(busy), 8'h00);

        // Empty mask, then CLEAR (with a command rejected while in CLR).
        trigger_channel_mask = 8'h00;
        send(OP_SOFT, 1'b1);
        step(4);
        check_outs("mask0", 0, 0, 0, 0, 1, 8'd2, 8'h00);
        send(OP_CLEAR, 1'b1);
        step(3);
        check_outs("clr_entry", 0, 1, 0, 1, 0, 8'd0, 8'h00);
        send(OP_NOP, 1'b1);
        step(3);
        check("clr_cmd_err", 8'(cmd_err), 8'h01);
        step(4);
        check("clr_last_cycle", 8'(clear_out), 8'h01);
        step(1);
        check("clr_done", 8'(clear_out), 8'h00);
        check("clr_done_busy", 8'(busy), 8'h00);

        // CLEAR while in TRIG.
        trigger_channel_mask = 8'h22;
        send(OP_SOFT, 1'b1);
        exp_q.push_back(sb_t'({8'h22, 8'd1}));
        step(3);
        check("abort_trig_on", trig_out, 8'h22);
        send(OP_CLEAR, 1'b1);
        step(3);
        check_outs("abort", 0, 1, 0, 1, 0, 8'd0, 8'h00);
        step(8);
        check("abort_idle", 8'(busy), 8'h00);

        // Readout with no ack.
        mode = 8'h01;
        send(OP_READOUT, 1'b1);
        step(3);
        check("tmo_req_on", 8'(readout_req), 8'h01);
`ifdef ACQ_READOUT_TIMEOUT_EN
        step(15);
        check("tmo_req_last", 8'(readout_req), 8'h01);
        step(1);
        check("tmo_req_drop", 8'(readout_req), 8'h00);
        check("tmo_err", 8'(timeout_err), 8'h01);
        check("tmo_idle_busy", 8'(busy), 8'h00);
        check("tmo_idle_acq", 8'(acq_en), 8'h00);
`else
        step(40);
        check("noto_req_held", 8'(readout_req), 8'h01);
        check("noto_err", 8'(timeout_err), 8'h00);
        ack_pulse();
        check("noto_rearm", 8'(acq_en), 8'h01);
`endif
        send(OP_CLEAR, 1'b1);
        step(3);
        check("final_clr_timeout_err", 8'(timeout_err), 8'h00);
        check("final_clr_on", 8'(clear_out), 8'h01);
        step(8);
        check("final_idle", 8'(busy), 8'h00);

        check("sb_empty", 8'(exp_q.size()), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
